dmem_arbiter: RTL and testbench

Shares the single-ported 512x32 data memory between core 0 and core 1 of the dual-core MIPS system. Accepts load, store and exchange requests from each core and grants one at a time by round-robin. An exchange is performed as an indivisible read-then-write, so no other access reaches memory between its two phases; this is what makes the spin-lock (`exchng` then `sw $0`) correct. Sits between the two cores' MEM stages and the synchronous data RAM.

---
 rtl/dmem_arb_pkg.sv | 25 ++
 rtl/rr_arb2.sv | 17 +
 rtl/dmem_arbiter.sv | 118 +++++++++++
 tb/tb_dmem_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the dual-core data-memory arbiter: operation codes,
// FSM state encoding and default bus widths.
package dmem_arb_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 9;

   localparam logic [1:0] OP_LD   = 2'b00;
   localparam logic [1:0] OP_ST   = 2'b01;
   localparam logic [1:0] OP_XCHG = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_XWR,
      S_DONE
   } state_e;

   // The reserved encoding behaves as a load.
   function automatic logic [1:0] norm_op(input logic [1:0] op);
      return (op == OP_ST || op == OP_XCHG) ? op : OP_LD;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker. ptr=0 favours requester 0 on a tie; when
// update is high and a grant is made, the pointer moves to favour the loser.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       ptr,
   input  logic       update,
   output logic [1:0] grant,
   output logic       ptr_next
);

   always_comb begin
      grant[0] = req[0] & (~req[1] | ~ptr);
      grant[1] = req[1] & ~grant[0];
      ptr_next = (update && (|grant)) ? grant[0] : ptr;
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous 512x32 data RAM between two
// MIPS cores; exchange is an indivisible read-then-write for spin-locks.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic [1:0]        op0,
   input  logic [1:0]        op1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              done0,
   output logic              done1,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   state_e              state_q, state_d;
   logic                owner_q;
   logic [1:0]          op_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                ptr_q, ptr_next;
   logic [1:0]          grant;
   logic                in_idle;

   assign in_idle = (state_q == S_IDLE);
   assign busy    = ~in_idle;

   // The pointer is committed as the grant is taken rather than at completion;
   // it is only consulted in IDLE, so the arbitration order is the same.
   rr_arb2 u_arb (
      .req      ({req1, req0}),
      .ptr      (ptr_q),
      .update   (in_idle),
      .grant    (grant),
      .ptr_next (ptr_next)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         ptr_q   <= 1'b0;
         owner_q <= 1'b0;
         op_q    <= OP_LD;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register sees pre-edge values.
         state_q <= state_d;
         ptr_q   <= ptr_next;
         if (in_idle && (|grant)) begin
            owner_q <= grant[1];
            op_q    <= grant[1] ? norm_op(op1) : norm_op(op0);
            addr_q  <= grant[1] ? addr1 : addr0;
            wdata_q <= grant[1] ? wdata1 : wdata0;
         end
         if (state_q == S_WAIT) rdata_q <= mem_rdata;
      end
   end

   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      state_d   = state_q;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      done0     = 1'b0;
      done1     = 1'b0;
      rdata     = '0;
      unique case (state_q)
         S_IDLE: if (|grant) state_d = S_ISSUE;
         S_ISSUE: begin
            mem_en   = 1'b1;
            mem_addr = addr_q;
            if (op_q == OP_ST) begin
               mem_we    = 1'b1;
               mem_wdata = wdata_q;
               state_d   = S_DONE;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: state_d = (op_q == OP_XCHG) ? S_XWR : S_DONE;
         // Write-back of the exchange: no other strobe can slip in before it.
         S_XWR: begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            state_d   = S_DONE;
         end
         S_DONE: begin
            done0   = ~owner_q;
            done1   = owner_q;
            rdata   = (op_q == OP_ST) ? '0 : rdata_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural synchronous RAM, a strobe
// log and a completion log used to check ordering and exchange atomicity.
module tb_dmem_arbiter;
   import dmem_arb_pkg::*;

   localparam int DW = 32;
   localparam int AW = 9;
   localparam int LOCK_ITERS  = 1000;
   localparam int LOOP_BUDGET = 90000;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0, req1;
   logic [1:0]    op0, op1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          done0, done1;
   logic [DW-1:0] rdata;
   logic          busy, mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   logic          bd_we;
   logic [AW-1:0] bd_addr;
   logic [DW-1:0] bd_data;
   logic [DW-1:0] mem [512];

   typedef struct {
      int            cyc;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } strobe_t;

   strobe_t slog[$];
   int      dlog[$];
   int      total = 0;
   int      bad = 0;
   int      cyc = 0;
   int      loop_start = 0;
   logic    abort = 1'b0;

   always #5 clk = ~clk;

   dmem_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .req0      (req0),
      .req1      (req1),
      .op0       (op0),
      .op1       (op1),
      .addr0     (addr0),
      .addr1     (addr1),
      .wdata0    (wdata0),
      .wdata1    (wdata1),
      .done0     (done0),
      .done1     (done1),
      .rdata     (rdata),
      .busy      (busy),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bd_we) mem[bd_addr] <= bd_data;
      else if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata <= mem[mem_addr];
      end
   end

   always @(negedge clk) begin
      if (mem_en) slog.push_back('{cyc: cyc, we: mem_we, addr: mem_addr, wdata: mem_wdata});
      if (done0) dlog.push_back(0);
      if (done1) dlog.push_back(1);
   end

   initial begin
      #(10 * 150000);
      $display("FAIL watchdog: simulation did not finish, got running want finished");
      $fatal(1);
   end

   task automatic bd_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      bd_we = 1'b1; bd_addr = a; bd_data = d;
      @(negedge clk);
      bd_we = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   // Issue one request from core c at the current negedge and wait for its done.
   task automatic core_access(input int c, input logic [1:0] op, input logic [AW-1:0] a,
                              input logic [DW-1:0] wd, output logic [DW-1:0] rd,
                              output int lat, output int dcyc);
      logic seen;
      seen = 1'b0; lat = 0; rd = '0; dcyc = -1;
      if (c == 0) begin req0 = 1'b1; op0 = op; addr0 = a; wdata0 = wd; end
      else        begin req1 = 1'b1; op1 = op; addr1 = a; wdata1 = wd; end
      while (!seen && lat < 40) begin
         @(negedge clk);
         lat++;
         if ((c == 0) ? done0 : done1) begin
            seen = 1'b1; rd = rdata; dcyc = cyc;
         end
      end
      if (c == 0) req0 = 1'b0; else req1 = 1'b0;
      if (!seen) begin
         total++; bad++;
         $display("FAIL timeout core%0d op=%0d addr=%0d: done got none want within 40 cycles", c, op, a);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      req0 = 1'b0; req1 = 1'b0; op0 = '0; op1 = '0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      bd_we = 1'b0; bd_addr = '0; bd_data = '0;
      repeat (2) @(negedge clk);
      total++; if ({done0, done1} !== 2'b00) begin bad++; $display("FAIL reset_done got=%b want=00", {done0, done1}); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if ({mem_en, mem_we} !== 2'b00) begin bad++; $display("FAIL reset_strobe got=%b want=00", {mem_en, mem_we}); end
      total++; if (mem_addr !== '0) begin bad++; $display("FAIL reset_addr got=%h want=0", mem_addr); end
      total++; if (mem_wdata !== '0) begin bad++; $display("FAIL reset_wdata got=%h want=0", mem_wdata); end
      total++; if (rdata !== '0) begin bad++; $display("FAIL reset_rdata got=%h want=0", rdata); end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_store_load();
      logic [DW-1:0] rd;
      int lat, dc;
      req0 = 1'b1; op0 = OP_ST; addr0 = 9'd5; wdata0 = 32'h2A;
      @(negedge clk);
      total++;
      if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 9'd5, 32'h2A}) begin
         bad++; $display("FAIL st_c1_strobe got en=%b we=%b a=%0d d=%h want en=1 we=1 a=5 d=2a", mem_en, mem_we, mem_addr, mem_wdata);
      end
      total++; if (done0 !== 1'b0) begin bad++; $display("FAIL st_c1_done got=%b want=0", done0); end
      @(negedge clk);
      total++; if ({done0, rdata} !== {1'b1, 32'h0}) begin bad++; $display("FAIL st_c2_done got done0=%b rdata=%h want 1/0", done0, rdata); end
      req0 = 1'b0;
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL st_idle_busy got=%b want=0", busy); end
      req0 = 1'b1; op0 = OP_LD; addr0 = 9'd5; wdata0 = 32'hDEAD;
      @(negedge clk);
      total++;
      if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b0, 9'd5, 32'h0}) begin
         bad++; $display("FAIL ld_c1_strobe got en=%b we=%b a=%0d d=%h want en=1 we=0 a=5 d=0", mem_en, mem_we, mem_addr, mem_wdata);
      end
      @(negedge clk);
      total++; if ({done0, busy, mem_en} !== 3'b010) begin bad++; $display("FAIL ld_c2_wait got done0/busy/en=%b want 010", {done0, busy, mem_en}); end
      @(negedge clk);
      total++; if ({done0, rdata} !== {1'b1, 32'h2A}) begin bad++; $display("FAIL ld_c3_done got done0=%b rdata=%h want 1/2a", done0, rdata); end
      req0 = 1'b0;
      @(negedge clk);
      core_access(0, 2'b11, 9'd5, 32'hFFFF_FFFF, rd, lat, dc);
      total++; if (rd !== 32'h2A || lat !== 3) begin bad++; $display("FAIL reserved_op got rdata=%h lat=%0d want 2a/3", rd, lat); end
      total++; if (mem[5] !== 32'h2A) begin bad++; $display("FAIL reserved_op_mem got=%h want=2a", mem[5]); end
      @(negedge clk);
      core_access(1, OP_ST, 9'd6, 32'hBEEF_0001, rd, lat, dc);
      total++; if (lat !== 2 || mem[6] !== 32'hBEEF_0001) begin bad++; $display("FAIL core1_store got lat=%0d mem6=%h want 2/beef0001", lat, mem[6]); end
      @(negedge clk);
   endtask

   task automatic test_arbitration();
      logic [DW-1:0] rd0, rd1, tmp;
      int lat0, lat1, dc0, dc1, mark;
      do_reset();
      bd_write(9'd20, 32'h200);
      bd_write(9'd21, 32'h211);
      fork
         core_access(0, OP_LD, 9'd20, 32'h0, rd0, lat0, dc0);
         core_access(1, OP_LD, 9'd21, 32'h0, rd1, lat1, dc1);
      join
      total++; if (rd0 !== 32'h200 || lat0 !== 3) begin bad++; $display("FAIL tie_core0 got rdata=%h lat=%0d want 200/3", rd0, lat0); end
      total++; if (rd1 !== 32'h211 || lat1 !== 7) begin bad++; $display("FAIL tie_core1 got rdata=%h lat=%0d want 211/7", rd1, lat1); end
      @(negedge clk);
      mark = dlog.size();
      fork
         begin
            core_access(0, OP_LD, 9'd20, 32'h0, tmp, lat0, dc0);
            core_access(0, OP_LD, 9'd20, 32'h0, tmp, lat0, dc0);
         end
         begin
            core_access(1, OP_LD, 9'd21, 32'h0, rd1, lat1, dc1);
            core_access(1, OP_LD, 9'd21, 32'h0, rd1, lat1, dc1);
         end
      join
      @(negedge clk); #1;
      total++; if (dlog.size() - mark !== 4) begin bad++; $display("FAIL b2b_count got=%0d want=4", dlog.size() - mark); end
      else begin
         for (int i = 0; i < 4; i++) begin
            total++;
            if (dlog[mark + i] !== (i % 2)) begin bad++; $display("FAIL b2b_owner[%0d] got=%0d want=%0d", i, dlog[mark + i], i % 2); end
         end
      end
   endtask

   task automatic test_lock_xchg();
      logic [DW-1:0] rd0, rd1;
      int lat0, lat1, dc0, dc1, mark;
      bd_write(9'd10, 32'h0);
      mark = slog.size();
      fork
         core_access(0, OP_XCHG, 9'd10, 32'h1, rd0, lat0, dc0);
         core_access(1, OP_XCHG, 9'd10, 32'h1, rd1, lat1, dc1);
      join
      @(negedge clk); #1;
      total++; if (rd0 !== 32'h0 || lat0 !== 4) begin bad++; $display("FAIL xchg_winner got rdata=%h lat=%0d want 0/4", rd0, lat0); end
      total++; if (rd1 !== 32'h1) begin bad++; $display("FAIL xchg_loser got rdata=%h want 1", rd1); end
      total++; if (mem[10] !== 32'h1) begin bad++; $display("FAIL xchg_mem got=%h want=1", mem[10]); end
      total++;
      if (slog.size() - mark !== 4) begin bad++; $display("FAIL xchg_strobes got=%0d want=4", slog.size() - mark); end
      else if (slog[mark].we !== 1'b0 || slog[mark + 1].we !== 1'b1 || slog[mark + 1].addr !== 9'd10
               || slog[mark + 1].wdata !== 32'h1 || slog[mark + 1].cyc - slog[mark].cyc !== 2) begin
         bad++; $display("FAIL xchg_atomic got we=%b,%b gap=%0d want 0,1 gap=2", slog[mark].we, slog[mark + 1].we,
                         slog[mark + 1].cyc - slog[mark].cyc);
      end
   endtask

   task automatic test_xchg_vs_store();
      logic [DW-1:0] rd0, rd1;
      int lat0, lat1, dc0, dc1, mark, wcyc;
      bd_write(9'd30, 32'h11);
      mark = slog.size();
      fork
         core_access(0, OP_XCHG, 9'd30, 32'h55, rd0, lat0, dc0);
         begin
            @(negedge clk);
            core_access(1, OP_ST, 9'd30, 32'h77, rd1, lat1, dc1);
         end
      join
      @(negedge clk); #1;
      wcyc = -1;
      for (int i = mark; i < slog.size(); i++)
         if (slog[i].we && slog[i].wdata == 32'h77) wcyc = slog[i].cyc;
      total++; if (rd0 !== 32'h11) begin bad++; $display("FAIL xs_old got=%h want=11", rd0); end
      total++; if (wcyc <= dc0) begin bad++; $display("FAIL xs_order got store_cyc=%0d want > done0_cyc=%0d", wcyc, dc0); end
      total++; if (lat1 !== 6 || mem[30] !== 32'h77) begin bad++; $display("FAIL xs_store got lat=%0d mem=%h want 6/77", lat1, mem[30]); end
   endtask

   task automatic test_reset_mid_xchg();
      int markd, marks, writes;
      bd_write(9'd40, 32'h99);
      markd = dlog.size();
      marks = slog.size();
      req0 = 1'b1; op0 = OP_XCHG; addr0 = 9'd40; wdata0 = 32'hAB;
      @(negedge clk);
      @(negedge clk);
      total++; if (busy !== 1'b1 || mem_en !== 1'b0) begin bad++; $display("FAIL rx_wait got busy=%b en=%b want 1/0", busy, mem_en); end
      #2 rst = 1'b0;
      #1;
      total++; if ({busy, mem_en, mem_we, done0, done1} !== 5'b0) begin bad++; $display("FAIL rx_ctrl got=%b want=00000", {busy, mem_en, mem_we, done0, done1}); end
      total++; if ({mem_addr, mem_wdata, rdata} !== '0) begin bad++; $display("FAIL rx_data got a=%h d=%h r=%h want 0", mem_addr, mem_wdata, rdata); end
      req0 = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      writes = 0;
      for (int i = marks; i < slog.size(); i++) if (slog[i].we) writes++;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rx_idle got busy=%b want=0", busy); end
      total++; if (mem[40] !== 32'h99 || writes !== 0) begin bad++; $display("FAIL rx_mem got=%h writes=%0d want 99/0", mem[40], writes); end
      total++; if (dlog.size() !== markd) begin bad++; $display("FAIL rx_nodone got=%0d want=%0d", dlog.size(), markd); end
   endtask

   task automatic core_loop(input int c);
      logic [DW-1:0] r;
      int lat, dc;
      for (int i = 0; i < LOCK_ITERS && !abort; i++) begin
         r = 32'h1;
         while (r !== 32'h0 && !abort) begin
            core_access(c, OP_XCHG, 9'd10, 32'h1, r, lat, dc);
            if (dc < 0 || cyc - loop_start > LOOP_BUDGET) abort = 1'b1;
         end
         if (!abort) core_access(c, OP_LD, 9'd5, 32'h0, r, lat, dc);
         if (!abort) core_access(c, OP_ST, 9'd5, r + 32'h1, r, lat, dc);
         if (!abort) core_access(c, OP_ST, 9'd10, 32'h0, r, lat, dc);
         if (dc < 0) abort = 1'b1;
      end
   endtask

   task automatic test_lock_loop();
      do_reset();
      bd_write(9'd5, 32'h0);
      bd_write(9'd10, 32'h0);
      loop_start = cyc;
      fork
         core_loop(0);
         core_loop(1);
      join
      @(negedge clk);
      total++; if (abort !== 1'b0) begin bad++; $display("FAIL loop_abort got aborted want completed"); end
      total++; if (mem[5] !== 32'd2000) begin bad++; $display("FAIL loop_count got=%0d want=2000", mem[5]); end
      total++; if (mem[10] !== 32'h0) begin bad++; $display("FAIL loop_lock got=%h want=0", mem[10]); end
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_arbitration();
      test_lock_xchg();
      test_xchg_vs_store();
      test_reset_mid_xchg();
      test_lock_loop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
